// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and
// default bit timing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // 48 MHz / 417 gives roughly 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 417;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with occupancy count; push when full and pop when
// empty are ignored so queued data is never overwritten or replayed.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic [4:0] count,
  output logic [4:0] count_next
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != 5'(DEPTH));
  assign do_pop  = pop && (count != 5'd0);
  assign rd_data = mem[rd_ptr];

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 5'd1;
      2'b01:   count_next = count - 5'd1;
      default: count_next = count;
    endcase
  end

  // Storage, pointers (wrapping at the power-of-two depth) and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'd0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter fed from a small byte FIFO; frames are sent
// back-to-back with no idle gap while data is queued.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       pin_tx,
  output logic       busy,
  output logic [4:0] fifo_level
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_t   state;
  tx_state_t   state_next;
  logic [15:0] baud_cnt;
  logic [15:0] baud_next;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_next;
  logic [7:0]  shift;
  logic [7:0]  shift_next;
  logic        tx_next;
  logic        push;
  logic        pop;
  logic        fifo_empty;
  logic        bit_end;
  logic [7:0]  fifo_head;
  logic [4:0]  level_next;

  assign push       = in_valid && in_ready;
  assign fifo_empty = (fifo_level == 5'd0);
  assign bit_end    = (baud_cnt == BAUD_LAST);

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk_48mhz),
    .rst_n      (reset),
    .push       (push),
    .pop        (pop),
    .wr_data    (in_data),
    .rd_data    (fifo_head),
    .count      (fifo_level),
    .count_next (level_next)
  );

  // Frame sequencing, baud timing and the next serial line level
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    tx_next    = 1'b1;

    case (state)
      IDLE: begin
        baud_next = 16'd0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_head;
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          baud_next  = 16'd0;
          bit_next   = 3'd0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next = 16'd0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next   = bit_idx + 3'd1;
            shift_next = {1'b0, shift[7:1]};
          end
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_next = 16'd0;
          // Chain straight into the next start bit when data is waiting
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_head;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      default: begin
        baud_next  = 16'd0;
        state_next = IDLE;
      end
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  // State and outputs are registered from next-state values so they change only on the clock
  always_ff @(posedge clk_48mhz or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
      pin_tx   <= 1'b1;
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      pin_tx   <= tx_next;
      in_ready <= (level_next != 5'(FIFO_DEPTH));
      busy     <= (state_next != IDLE) || (level_next != 5'd0);
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a frame-level model of the serial line and FIFO occupancy.
module tb_uart_tx_serializer;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk_48mhz = 1'b0;
  logic       reset     = 1'b0;
  logic [7:0] in_data   = 8'd0;
  logic       in_valid  = 1'b0;
  logic       in_ready;
  logic       pin_tx;
  logic       busy;
  logic [4:0] fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_48mhz  (clk_48mhz),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pin_tx     (pin_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line level k cycles into a frame carrying byte b (8N1, LSB first)
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k < CPB) return 1'b0;
    else if (k < 9 * CPB) return b[(k - CPB) / CPB];
    else return 1'b1;
  endfunction

  // Reference model: accepted bytes queue, push/pop totals and the frame on the wire
  logic [7:0] model_q[$];
  int         push_cnt  = 0;
  int         last_push = 0;
  int         pop_cnt   = 0;
  bit         active    = 1'b0;
  int         k         = 0;
  logic [7:0] cur       = 8'd0;
  bit         seen_full = 1'b0;

  always @(posedge clk_48mhz) begin
    if (!reset) begin
      push_cnt <= 0;
      model_q.delete();
    end else if (in_valid && in_ready) begin
      model_q.push_back(in_data);
      push_cnt <= push_cnt + 1;
    end
  end

  always @(negedge clk_48mhz) begin
    int  lvl_prev;
    int  lvl;
    logic exp_pin;
    if (!reset) begin
      pop_cnt   = 0;
      last_push = 0;
      active    = 1'b0;
      k         = 0;
      check_value("rst_pin_tx", pin_tx, 1);
      check_value("rst_in_ready", in_ready, 0);
      check_value("rst_busy", busy, 0);
      check_value("rst_fifo_level", fifo_level, 0);
    end else begin
      lvl_prev = last_push - pop_cnt;
      if (active) begin
        k++;
        if (k == FRAME) active = 1'b0;
      end
      if (!active && lvl_prev > 0 && model_q.size() > 0) begin
        cur    = model_q.pop_front();
        pop_cnt++;
        active = 1'b1;
        k      = 0;
      end
      last_push = push_cnt;
      lvl       = push_cnt - pop_cnt;
      exp_pin   = active ? frame_bit(cur, k) : 1'b1;
      check_value("pin_tx", pin_tx, exp_pin);
      check_value("fifo_level", fifo_level, lvl);
      check_value("in_ready", in_ready, (lvl != DEPTH));
      check_value("busy", busy, (active || lvl != 0));
      if (fifo_level == 5'd4 && in_ready == 1'b0) seen_full = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_48mhz);
      #1;
    end
  endtask

  // Offer bytes in order, holding in_valid until each is accepted
  task automatic send_seq(input logic [7:0] bytes[$], input int budget);
    int i = 0;
    int t = 0;
    logic go;
    while (i < bytes.size() && t < budget) begin
      in_valid = 1'b1;
      in_data  = bytes[i];
      go       = in_ready;
      tick(1);
      t++;
      if (go) i++;
    end
    in_valid = 1'b0;
    if (i < bytes.size()) check_value("send_timeout", i, bytes.size());
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (busy !== 1'b0 && cycles < budget) begin
      tick(1);
      cycles++;
    end
    if (busy !== 1'b0) check_value("idle_timeout", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bq[$];
    int cyc;

    tick(3);
    reset = 1'b1;
    tick(1);
    check_value("ready_after_reset", in_ready, 1);

    // Single byte: busy spans acceptance edge plus one full frame
    bq = '{8'hA5};
    send_seq(bq, 10);
    wait_idle(200, cyc);
    check_value("single_busy_cycles", cyc, FRAME + 1);
    tick(2);

    // Back-to-back frames with no idle gap
    bq = '{8'h00, 8'hFF};
    send_seq(bq, 10);
    wait_idle(300, cyc);
    check_value("b2b_busy_cycles", cyc, 2 * FRAME);
    tick(2);

    // Six bytes with in_valid held: FIFO fills and backpressures
    seen_full = 1'b0;
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_seq(bq, 200);
    check_value("full_seen", seen_full, 1);
    wait_idle(600, cyc);
    tick(2);

    // Push coinciding with pop at level 2
    bq = '{8'h21, 8'h42, 8'h63};
    send_seq(bq, 10);
    check_value("pp_level_before", fifo_level, 2);
    tick(38);
    check_value("pp_level_pre_edge", fifo_level, 2);
    in_valid = 1'b1;
    in_data  = 8'h84;
    tick(1);
    in_valid = 1'b0;
    check_value("pp_level_after", fifo_level, 2);
    wait_idle(400, cyc);
    tick(2);

    // Asynchronous reset in the middle of a frame
    bq = '{8'h3C, 8'h11};
    send_seq(bq, 10);
    tick(14);
    reset = 1'b0;
    #1;
    check_value("abort_pin_tx", pin_tx, 1);
    check_value("abort_fifo_level", fifo_level, 0);
    check_value("abort_busy", busy, 0);
    check_value("abort_in_ready", in_ready, 0);
    tick(2);
    reset = 1'b1;
    tick(1);
    check_value("ready_after_abort", in_ready, 1);
    bq = '{8'h55};
    send_seq(bq, 10);
    wait_idle(200, cyc);
    check_value("post_abort_busy_cycles", cyc, FRAME + 1);
    tick(2);

    // Random traffic, including in_valid while in_ready is low
    for (int i = 0; i < 700; i++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = 8'($urandom);
      tick(1);
    end
    in_valid = 1'b0;
    wait_idle(1000, cyc);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 417, meaning clk_48mhz cycles per serial bit (417 gives about 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning byte FIFO entries; must be a power of two, 2..16.
REQ-003 SHALL have port clk_48mhz, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_data, input, 8 bits: byte from the host-to-device pipeline (driven by usb_uart uart_out_data).
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a byte this cycle.
REQ-008 SHALL have port pin_tx, output, 1 bit: serial line; idle high.
REQ-009 SHALL have port busy, output, 1 bit: high when a frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have port fifo_level, output, 5 bits: current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-011 SHALL accept a byte on a rising edge where in_valid and in_ready are both high; no other condition writes the FIFO.
REQ-012 SHALL drive in_ready = (fifo_level != FIFO_DEPTH) from registered state only; a same-cycle pop SHALL NOT make in_ready high while full.
REQ-013 SHALL ignore in_data whenever in_valid is low; in_valid high with in_ready low SHALL NOT change state.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE: pin_tx = 1; if FIFO is non-empty, SHALL pop the head into the shift register and enter START on the same edge.
REQ-016 START: pin_tx = 0 for CLKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-017 DATA: SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles; after bit 7, enter STOP.
REQ-018 STOP: pin_tx = 1 for CLKS_PER_BIT cycles; at the end, if FIFO is non-empty, SHALL pop and enter START directly with no idle gap; otherwise enter IDLE.
REQ-019 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles (8N1; no parity).
REQ-020 Latency: for a byte accepted into an empty FIFO while IDLE at edge N, pin_tx SHALL fall after edge N+1.
REQ-021 pin_tx SHALL be driven from a flop (glitch-free).
REQ-022 On a simultaneous push and pop, fifo_level SHALL stay unchanged and byte order SHALL be preserved.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the block SHALL never overwrite unsent data or pop when empty.
REQ-024 The baud counter SHALL count 0..CLKS_PER_BIT-1 and restart at each bit boundary; it SHALL be held at 0 in IDLE.
REQ-025 busy SHALL equal (state != IDLE) || (fifo_level != 0).

Reset
REQ-026 While reset is low: pin_tx = 1, in_ready = 0, busy = 0, fifo_level = 0, FSM = IDLE, counters and pointers = 0.
REQ-027 in_ready SHALL rise on the first clock edge after reset deasserts.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately (pin_tx high asynchronously) and discard FIFO contents.

Structure
REQ-029 A shared package uart_pkg SHALL hold the FSM state enum and the default CLKS_PER_BIT constant.
REQ-030 The FIFO SHALL be a sub-module byte_fifo (synchronous, parameterised depth, count output); the FSM and baud counter stay in the top module.

Verification (CLKS_PER_BIT = 4, FIFO_DEPTH = 4)
REQ-031 Single byte: push 0xA5 when idle -> pin_tx low after 1 cycle, then bits 1,0,1,0,0,1,0,1, then high; 40 cycles total; busy low afterwards.
REQ-032 Back-to-back: push 0x00 then 0xFF -> two frames with no high gap between the stop bit and the next start bit; 80 cycles.
REQ-033 Full FIFO: hold in_valid high with 6 bytes 0x01..0x06 -> in_ready low when fifo_level = 4 with one frame in flight; all 6 bytes emitted in order.
REQ-034 Push and pop in the same cycle at fifo_level = 2 -> level stays 2; order intact.
REQ-035 Reset mid-frame at cycle 15 of 0x3C -> pin_tx = 1 immediately, fifo_level = 0; in_ready = 1 one edge after release; next byte 0x55 is sent correctly.
REQ-036 in_valid pulses while in_ready is low -> no byte accepted; output stream unchanged.
